timersoc_ram_arbiter: RTL and testbench
=======================================

# timersoc_ram_arbiter

Two-master arbiter that shares the single-port 8192×32 on-chip SoC RAM between the CPU data master (port m0) and a secondary master such as the timer capture/DMA engine (port m1). It sits between the Avalon-MM interconnect and the RAM wrapper. It performs round-robin arbitration with an optional lock and tracks the RAM's one-cycle read latency to route read data back with `readdatavalid`.

## Interface
Parameters:
- ADDR_W, 13, word address width (8192 words)
- DATA_W, 32, data width; byteenable width is DATA_W/8
- LOCK_MAX, 16, max consecutive locked grants while the other master waits (1..255)

Ports:
- clk  in  1  single system clock, all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- mX_address  in  ADDR_W  word address, X = 0,1 (per-master ports repeat for m0 and m1)
- mX_byteenable  in  DATA_W/8  byte lanes for writes
- mX_read  in  1  read request
- mX_write  in  1  write request
- mX_writedata  in  DATA_W  write data
- mX_lock  in  1  hold grant after this transfer
- mX_waitrequest  out  1  high = transfer not accepted this cycle
- mX_readdata  out  DATA_W  read data
- mX_readdatavalid  out  1  one-cycle strobe, readdata valid
- ram_address  out  ADDR_W  to RAM
- ram_byteenable  out  DATA_W/8  to RAM
- ram_chipselect  out  1  to RAM
- ram_write  out  1  to RAM
- ram_writedata  out  DATA_W  to RAM
- ram_clken  out  1  RAM clock enable, tied high when out of reset
- ram_readdata  in  DATA_W  RAM output, valid one cycle after a read is presented
- proto_err  out  1  sticky: a master asserted read and write together

## Operation
- Request: reqX = mX_read | mX_write.
- Arbitration (combinational, every cycle):
  - Only one requester: that requester wins.
  - Both requesting: the master that did not win last wins (round-robin pointer `last`).
  - Lock active: the locked master wins whenever it requests.
- Grant gX forces mX_waitrequest=0. The other requester sees waitrequest=1. A non-requesting master sees waitrequest=1.
- RAM mux: ram_* driven from the granted master. ram_chipselect=1 only when there is a grant, else 0, and address/data hold the last value. ram_write = granted write.
- Read tracking: a register `rd_pend`/`rd_tag` captures (granted read, winner index). On the next cycle, the tagged master gets readdatavalid=1 and readdata=ram_readdata. mX_readdata is driven from ram_readdata at all times, so only readdatavalid is gated.
- Lock state machine, states UNLOCKED and LOCKED(owner):
  - UNLOCKED→LOCKED(X) on a granted transfer with mX_lock=1.
  - LOCKED→UNLOCKED on a granted owner transfer with lock=0.
  - LOCKED→UNLOCKED when lock_cnt reaches LOCK_MAX while the other master requests. That master is then granted next.
  - lock_cnt counts consecutive owner grants while the other master is pending. It clears on every state change. While LOCKED with the owner idle, no one is granted (the other master waits).
- Read and write asserted together: treated as a write. proto_err sets and stays set until reset.
- `last` updates to the winner on every granted cycle.

## Timing
- Reset values: all mX_waitrequest=1, mX_readdatavalid=0, ram_chipselect=0, ram_write=0, ram_clken=0, proto_err=0, last=1 (m0 wins the first contention), state UNLOCKED, lock_cnt=0, rd_pend=0.
- Accept latency is 0: waitrequest drops in the same cycle the request is seen, if granted.
- Read latency: request accepted in cycle N, readdatavalid in N+1. Back-to-back reads give one result per cycle.
- A write completes in its accept cycle. A read in N+1 to the address written in N returns the new data.
- Reset asserted mid-read: a pending readdatavalid is dropped and never appears after reset release.
- Maximum wait for a requester with no lock active: 1 cycle. With a lock active: LOCK_MAX+1 cycles.

## Structure
- Package timersoc_ram_arb_pkg holds: ADDR_W/DATA_W defaults, `lock_state_t` enum {UNLOCKED, LOCKED}, and the master index type (1 bit).
- Sub-module rr_arb2 holds the 2-input round-robin grant, the `last` pointer, the lock FSM and lock_cnt. The top level holds the RAM mux, the read-tag pipeline and proto_err.

## Test plan
- m0 reads addr 0x0010 (preloaded 0xDEADBEEF), m1 idle → m0_waitrequest=0 in cycle N; m0_readdatavalid=1 with 0xDEADBEEF in N+1; m1_readdatavalid stays 0.
- m0 and m1 both request continuously after reset → grants alternate m0,m1,m0,…; each waitrequest low every other cycle.
- m1 writes 0x12345678 with byteenable 4'b0011 to 0x1FFF, then m0 reads 0x1FFF next cycle → m0 receives 0x????5678, with the upper bytes equal to their prior contents.
- m0 holds lock=1 with back-to-back reads, m1 requesting, LOCK_MAX=4 → m0 gets 4 grants, then m1 is granted and the lock is released.
- m0 asserts read and write together → treated as a write and proto_err=1, still 1 after 10 idle cycles; returns to 0 only on reset_n.
- reset_n asserted one cycle after an accepted read → no readdatavalid after release; all outputs take their reset values while reset_n=0.

Source files
------------

// File: rtl/timersoc_ram_arb_pkg.sv
// Shared types and defaults for the SoC RAM two-master arbiter.
package timersoc_ram_arb_pkg;

  localparam int ADDR_W_DEF   = 13;
  localparam int DATA_W_DEF   = 32;
  localparam int LOCK_MAX_DEF = 16;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  // Master index: 0 = CPU data master, 1 = secondary master.
  typedef logic mst_idx_t;

endpackage

// File: rtl/timersoc_ram_arbiter_rr_arb2.sv
// Two-input round-robin grant with lock ownership and lock fairness counter.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// UNLOCKED | plain round robin; `last` picks the loser of the last contest
// LOCKED   | `owner` wins whenever it requests; the other master waits
//          | until the owner drops lock or lock_cnt hits LOCK_MAX
//
// lock_cnt counts the owner's consecutive grants while the other master is
// pending. The grant that takes the lock counts as the first of that run, so
// the owner gets exactly LOCK_MAX grants in front of a waiting master.
module rr_arb2
  import timersoc_ram_arb_pkg::*;
#(
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req0,
  input  logic req1,
  input  logic lock0,
  input  logic lock1,
  output logic gnt0,
  output logic gnt1
);

  localparam logic [7:0] CNT_MAX = 8'(LOCK_MAX);

  lock_state_t state, state_n;
  mst_idx_t    owner, owner_n;
  mst_idx_t    last, last_n;
  logic [7:0]  lock_cnt, lock_cnt_n;

  logic     owner_req, other_req;
  logic     any_gnt, win_lock, loser_req;
  mst_idx_t win;

  assign owner_req = owner ? req1 : req0;
  assign other_req = owner ? req0 : req1;
  assign any_gnt   = gnt0 | gnt1;
  assign win       = gnt1;
  assign win_lock  = win ? lock1 : lock0;
  assign loser_req = win ? req0 : req1;

  // State register: lock FSM, owner, round-robin pointer and fairness counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= UNLOCKED;
      owner    <= 1'b0;
      last     <= 1'b1;
      lock_cnt <= '0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      last     <= last_n;
      lock_cnt <= lock_cnt_n;
    end
  end

  // Next state: lock take/release, fairness count, pointer follows each winner.
  always_comb begin
    state_n    = state;
    owner_n    = owner;
    last_n     = last;
    lock_cnt_n = lock_cnt;
    if (any_gnt) last_n = win;
    case (state)
      UNLOCKED: begin
        if (any_gnt && win_lock) begin
          state_n    = LOCKED;
          owner_n    = win;
          lock_cnt_n = loser_req ? 8'd1 : 8'd0;
        end
      end
      LOCKED: begin
        if (any_gnt) begin
          if ((win != owner) || !win_lock) begin
            state_n    = UNLOCKED;
            lock_cnt_n = '0;
          end else if (other_req) begin
            lock_cnt_n = lock_cnt + 8'd1;
          end else begin
            lock_cnt_n = '0;
          end
        end
      end
      default: begin
        state_n    = UNLOCKED;
        lock_cnt_n = '0;
      end
    endcase
  end

  // Output: grants, suppressed entirely while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset_n) begin
      case (state)
        UNLOCKED: begin
          if (req0 && req1) begin
            gnt0 = last;
            gnt1 = ~last;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
        LOCKED: begin
          if (other_req && (lock_cnt == CNT_MAX)) begin
            gnt0 = owner;
            gnt1 = ~owner;
          end else if (owner_req) begin
            gnt0 = ~owner;
            gnt1 = owner;
          end
        end
        default: begin
          gnt0 = 1'b0;
          gnt1 = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/timersoc_ram_arbiter.sv
// Shares the single-port SoC RAM between the CPU data master (m0) and a
// secondary master (m1); routes one-cycle-latency read data back by tag.
module timersoc_ram_arbiter
  import timersoc_ram_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic                m0_lock,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic                m1_lock,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata,
  output logic                proto_err
);

  logic gnt0, gnt1;
  logic req0, req1;

  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W/8-1:0] be_q;
  logic [DATA_W-1:0]   wdata_q;

  logic     rd_pend;
  mst_idx_t rd_tag;
  logic     rd_accept;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  rr_arb2 #(
    .LOCK_MAX (LOCK_MAX)
  ) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req0    (req0),
    .req1    (req1),
    .lock0   (m0_lock),
    .lock1   (m1_lock),
    .gnt0    (gnt0),
    .gnt1    (gnt1)
  );

  assign m0_waitrequest = ~gnt0;
  assign m1_waitrequest = ~gnt1;

  // Read data is broadcast; only the valid strobe is steered by the tag.
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;
  assign m0_readdatavalid = rd_pend & (rd_tag == 1'b0);
  assign m1_readdatavalid = rd_pend & (rd_tag == 1'b1);

  assign ram_clken = reset_n;

  // RAM mux: winner drives the RAM; address/data hold their last value when idle.
  always_comb begin
    ram_address    = addr_q;
    ram_byteenable = be_q;
    ram_writedata  = wdata_q;
    ram_chipselect = gnt0 | gnt1;
    ram_write      = (gnt0 & m0_write) | (gnt1 & m1_write);
    if (gnt0) begin
      ram_address    = m0_address;
      ram_byteenable = m0_byteenable;
      ram_writedata  = m0_writedata;
    end else if (gnt1) begin
      ram_address    = m1_address;
      ram_byteenable = m1_byteenable;
      ram_writedata  = m1_writedata;
    end
  end

  // Capture the last presented address/data so idle cycles keep the bus stable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (ram_chipselect) begin
      addr_q  <= ram_address;
      be_q    <= ram_byteenable;
      wdata_q <= ram_writedata;
    end
  end

  // A read+write request is a write, so it never raises a read tag.
  assign rd_accept = (gnt0 & m0_read & ~m0_write) | (gnt1 & m1_read & ~m1_write);

  // Read tag pipeline: one stage matching the RAM's read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend <= 1'b0;
      rd_tag  <= 1'b0;
    end else begin
      rd_pend <= rd_accept;
      rd_tag  <= gnt1;
    end
  end

  // Sticky protocol error on read and write asserted together by either master.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      proto_err <= 1'b0;
    end else if ((m0_read & m0_write) | (m1_read & m1_write)) begin
      proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_timersoc_ram_arbiter.sv
// Self-checking bench: cycle vectors for grants/mux, scoreboard for read data.
module tb_timersoc_ram_arbiter;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int LM = 4;

  logic          clk;
  logic          reset_n;
  logic [AW-1:0] m0_address, m1_address;
  logic [3:0]    m0_byteenable, m1_byteenable;
  logic          m0_read, m0_write, m0_lock;
  logic          m1_read, m1_write, m1_lock;
  logic [DW-1:0] m0_writedata, m1_writedata;
  logic          m0_waitrequest, m1_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic [AW-1:0] ram_address;
  logic [3:0]    ram_byteenable;
  logic          ram_chipselect, ram_write, ram_clken;
  logic [DW-1:0] ram_writedata;
  logic [DW-1:0] ram_readdata;
  logic          proto_err;

  timersoc_ram_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .LOCK_MAX (LM)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_lock          (m0_lock),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_lock          (m1_lock),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .ram_address      (ram_address),
    .ram_byteenable   (ram_byteenable),
    .ram_chipselect   (ram_chipselect),
    .ram_write        (ram_write),
    .ram_writedata    (ram_writedata),
    .ram_clken        (ram_clken),
    .ram_readdata     (ram_readdata),
    .proto_err        (proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] preload(int a);
    if (a == 'h10)   return 32'hDEADBEEF;
    if (a == 'h1FFF) return 32'hAABBCCDD;
    return 32'hC0DE0000 | 32'(a);
  endfunction

  // Synchronous single-port RAM model with byte lanes and one-cycle read.
  logic [31:0] mem [0:8191];
  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = preload(i);
    ram_readdata = '0;
    forever begin
      @(posedge clk);
      if (ram_chipselect && ram_clken) begin
        if (ram_write) begin
          for (int b = 0; b < 4; b++)
            if (ram_byteenable[b]) mem[ram_address][8*b +: 8] = ram_writedata[8*b +: 8];
        end else begin
          ram_readdata = mem[ram_address];
        end
      end
    end
  end

  typedef struct {
    logic          r0, w0, l0;
    logic [AW-1:0] a0;
    logic [3:0]    be0;
    logic [31:0]   wd0;
    logic          r1, w1, l1;
    logic [AW-1:0] a1;
    logic [3:0]    be1;
    logic [31:0]   wd1;
    logic          xw0, xw1, xp;
  } vec_t;

  function automatic vec_t mk(logic r0, logic w0, logic l0, logic [AW-1:0] a0,
                              logic r1, logic w1, logic l1, logic [AW-1:0] a1,
                              logic xw0, logic xw1, logic xp);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.be0 = 4'hF;
    v.wd0 = 32'h5A000000 | 32'(a0);
    v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.be1 = 4'hF;
    v.wd1 = 32'hA5000000 | 32'(a1);
    v.xw0 = xw0; v.xw1 = xw1; v.xp = xp;
    return v;
  endfunction

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] ref_mem [0:8191];
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  vec_t        vecs[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(vec_t v);
    m0_read = v.r0; m0_write = v.w0; m0_lock = v.l0; m0_address = v.a0;
    m0_byteenable = v.be0; m0_writedata = v.wd0;
    m1_read = v.r1; m1_write = v.w1; m1_lock = v.l1; m1_address = v.a1;
    m1_byteenable = v.be1; m1_writedata = v.wd1;
  endtask

  task automatic ref_write(logic [AW-1:0] a, logic [3:0] be, logic [31:0] wd);
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
  endtask

  // One bus cycle: drive, check at the falling edge, update expectations.
  task automatic step(vec_t v);
    logic [31:0] e;
    drive(v);
    @(negedge clk);
    chk("rdv0", {31'b0, m0_readdatavalid}, {31'b0, q0.size() != 0});
    if (q0.size() != 0) begin
      e = q0.pop_front();
      if (m0_readdatavalid) chk("rdata0", m0_readdata, e);
    end
    chk("rdv1", {31'b0, m1_readdatavalid}, {31'b0, q1.size() != 0});
    if (q1.size() != 0) begin
      e = q1.pop_front();
      if (m1_readdatavalid) chk("rdata1", m1_readdata, e);
    end
    chk("wait0", {31'b0, m0_waitrequest}, {31'b0, v.xw0});
    chk("wait1", {31'b0, m1_waitrequest}, {31'b0, v.xw1});
    chk("chipselect", {31'b0, ram_chipselect}, {31'b0, !v.xw0 || !v.xw1});
    chk("ram_write", {31'b0, ram_write}, {31'b0, (!v.xw0 && v.w0) || (!v.xw1 && v.w1)});
    chk("proto_err", {31'b0, proto_err}, {31'b0, v.xp});
    chk("clken", {31'b0, ram_clken}, 32'd1);
    if (!v.xw0) begin
      chk("ram_addr0", {19'b0, ram_address}, {19'b0, v.a0});
      if (v.w0) begin
        chk("ram_wdata0", ram_writedata, v.wd0);
        ref_write(v.a0, v.be0, v.wd0);
      end else if (v.r0) q0.push_back(ref_mem[v.a0]);
    end
    if (!v.xw1) begin
      chk("ram_addr1", {19'b0, ram_address}, {19'b0, v.a1});
      if (v.w1) begin
        chk("ram_wdata1", ram_writedata, v.wd1);
        ref_write(v.a1, v.be1, v.wd1);
      end else if (v.r1) q1.push_back(ref_mem[v.a1]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset();
    chk("rst_wait0", {31'b0, m0_waitrequest}, 32'd1);
    chk("rst_wait1", {31'b0, m1_waitrequest}, 32'd1);
    chk("rst_rdv0", {31'b0, m0_readdatavalid}, 32'd0);
    chk("rst_rdv1", {31'b0, m1_readdatavalid}, 32'd0);
    chk("rst_cs", {31'b0, ram_chipselect}, 32'd0);
    chk("rst_write", {31'b0, ram_write}, 32'd0);
    chk("rst_clken", {31'b0, ram_clken}, 32'd0);
    chk("rst_proto", {31'b0, proto_err}, 32'd0);
  endtask

  initial begin
    vec_t idle;
    vec_t v;
    for (int i = 0; i < 8192; i++) ref_mem[i] = preload(i);
    idle = mk(0,0,0,13'h0, 0,0,0,13'h0, 1,1,0);
    reset_n = 1'b0;
    drive(idle);
    m0_read = 1'b1;
    m0_address = 13'h10;

    // Contention after reset alternates m0, m1, ...; then single-master traffic.
    vecs.push_back(mk(1,0,0,13'h020, 1,0,0,13'h021, 0,1,0));
    vecs.push_back(mk(1,0,0,13'h020, 1,0,0,13'h021, 1,0,0));
    vecs.push_back(mk(1,0,0,13'h022, 1,0,0,13'h023, 0,1,0));
    vecs.push_back(mk(1,0,0,13'h022, 1,0,0,13'h023, 1,0,0));
    vecs.push_back(mk(0,0,0,13'h000, 0,0,0,13'h000, 1,1,0));
    vecs.push_back(mk(1,0,0,13'h010, 0,0,0,13'h000, 0,1,0));
    vecs.push_back(mk(0,0,0,13'h000, 0,0,0,13'h000, 1,1,0));
    v = mk(0,0,0,13'h000, 0,1,0,13'h1FFF, 1,0,0);
    v.be1 = 4'b0011;
    v.wd1 = 32'h12345678;
    vecs.push_back(v);
    vecs.push_back(mk(1,0,0,13'h1FFF, 0,0,0,13'h000, 0,1,0));
    vecs.push_back(mk(0,0,0,13'h000, 0,0,0,13'h000, 1,1,0));
    vecs.push_back(mk(0,1,0,13'h060, 1,0,0,13'h061, 1,0,0));
    vecs.push_back(mk(0,1,0,13'h060, 0,0,0,13'h000, 0,1,0));
    vecs.push_back(mk(1,1,0,13'h030, 0,0,0,13'h000, 0,1,0));
    vecs.push_back(mk(0,0,0,13'h000, 0,0,0,13'h000, 1,1,1));
    vecs.push_back(mk(0,0,0,13'h000, 1,0,0,13'h062, 1,0,1));
    // Lock owner idle blocks the other master; unlock on an unlocked owner grant.
    vecs.push_back(mk(1,0,1,13'h040, 0,0,0,13'h000, 0,1,1));
    vecs.push_back(mk(0,0,0,13'h000, 1,0,0,13'h041, 1,1,1));
    vecs.push_back(mk(1,0,0,13'h040, 1,0,0,13'h041, 0,1,1));
    vecs.push_back(mk(0,0,0,13'h000, 1,0,0,13'h041, 1,0,1));
    // Lock held against a waiting m1: LOCK_MAX m0 grants, then m1, lock gone.
    for (int i = 0; i < LM; i++)
      vecs.push_back(mk(1,0,1,13'(13'h042 + i), 1,0,0,13'h043, 0,1,1));
    vecs.push_back(mk(1,0,1,13'h046, 1,0,0,13'h043, 1,0,1));
    vecs.push_back(mk(0,0,0,13'h000, 1,0,0,13'h044, 1,0,1));
    vecs.push_back(mk(0,0,0,13'h000, 0,0,0,13'h000, 1,1,1));

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    foreach (vecs[i]) step(vecs[i]);

    idle.xp = 1'b1;
    for (int i = 0; i < 10; i++) step(idle);

    // Reset arrives the cycle after an accepted read: its data must never show.
    step(mk(1,0,0,13'h050, 0,0,0,13'h000, 0,1,1));
    reset_n = 1'b0;
    idle.xp = 1'b0;
    drive(idle);
    @(negedge clk);
    check_reset();
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step(idle);

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
